// File: rtl/vga_score_tiles_if.sv
// Bus between the score tile writer and the game engine: run enable and score in,
// registered tile-RAM address/word out.
interface vga_score_tiles_if;
  logic        en;
  logic [15:0] num;
  logic [15:0] addr;
  logic [15:0] data;

  modport master (
    output en,
    output num,
    input  addr,
    input  data
  );

  modport slave (
    input  en,
    input  num,
    output addr,
    output data
  );
endinterface

// File: rtl/vga_score_tiles.sv
// Converts a saturated 16-bit score to four BCD digits by double-dabble and sweeps
// the matching glyph words (leading zeros blanked) into row START_ROW of the tile map.
module vga_score_tiles #(
  parameter int START_COL = 36,
  parameter int START_ROW = 0,
  parameter int TILE_COLS = 40,
  parameter int GLYPH_ROW = 4
) (
  input  logic              clk,
  input  logic              reset,
  vga_score_tiles_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam logic [15:0] BaseAddr = 16'(START_ROW * TILE_COLS + START_COL);
  localparam logic [2:0]  GlyphRow = 3'(GLYPH_ROW);
  localparam logic [13:0] MaxScore = 14'd9999;

  state_t      state_q, state_d;
  logic [3:0]  bitCnt_q, bitCnt_d;
  logic [1:0]  digIdx_q, digIdx_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;

  logic [15:0] bcdAdj;
  logic [3:0]  digit;
  logic        blank;
  logic [15:0] tileWord;

  // Double-dabble correction: any nibble of 5 or more would overflow past 9 when doubled.
  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int k = 0; k < 4; k++) begin
      if (b[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign bcdAdj = add3(bcd_q);

  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (digIdx_q)
      2'd0: begin
        digit = bcd_q[15:12];
        blank = (bcd_q[15:12] == 4'd0);
      end
      2'd1: begin
        digit = bcd_q[11:8];
        blank = (bcd_q[15:8] == 8'd0);
      end
      2'd2: begin
        digit = bcd_q[7:4];
        blank = (bcd_q[15:4] == 12'd0);
      end
      default: begin
        digit = bcd_q[3:0];
        blank = 1'b0;
      end
    endcase
  end

  // Glyphs 8 and 9 spill into the sheet row below the one holding 0..7.
  assign tileWord = blank ? 16'h0000
                          : {7'd0, 1'b1, 2'b00, GlyphRow + {2'd0, digit[3]}, digit[2:0]};

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    digIdx_d = digIdx_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (bus.en) begin
      case (state_q)
        LOAD: begin
          bin_d    = (bus.num > 16'(MaxScore)) ? MaxScore : bus.num[13:0];
          bcd_d    = 16'd0;
          bitCnt_d = 4'd13;
          state_d  = SHIFT;
        end
        SHIFT: begin
          {bcd_d, bin_d} = {bcdAdj[14:0], bin_q, 1'b0};
          if (bitCnt_q == 4'd0) begin
            digIdx_d = 2'd0;
            state_d  = EMIT;
          end else begin
            bitCnt_d = bitCnt_q - 4'd1;
          end
        end
        EMIT: begin
          addr_d   = BaseAddr + {14'd0, digIdx_q};
          data_d   = tileWord;
          digIdx_d = digIdx_q + 2'd1;
          if (digIdx_q == 2'd3) begin
            state_d = LOAD;
          end
        end
        default: begin
          state_d = LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOAD;
      bitCnt_q <= 4'd0;
      digIdx_q <= 2'd0;
      bin_q    <= 14'd0;
      bcd_q    <= 16'd0;
      addr_q   <= BaseAddr;
      data_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      digIdx_q <= digIdx_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign bus.addr = addr_q;
  assign bus.data = data_q;

endmodule

// File: tb/tb_vga_score_tiles.sv
// Directed bench for vga_score_tiles: a sweep-phase model queues the four expected
// words at every LOAD edge and compares them as the DUT emits them.
module tb_vga_score_tiles;

  logic clk;
  logic reset;
  int   testCount;
  int   failCount;
  int   cyc;
  logic [15:0] lastAddr;
  logic [15:0] lastData;
  logic [15:0] expAddrQ[$];
  logic [15:0] expDataQ[$];

  vga_score_tiles_if bus ();

  vga_score_tiles dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] expWord(input int value, input int idx);
    int s;
    int d[4];
    bit allZero;
    s = (value > 9999) ? 9999 : value;
    d[0] = s / 1000;
    d[1] = (s / 100) % 10;
    d[2] = (s / 10) % 10;
    d[3] = s % 10;
    allZero = 1'b1;
    for (int k = 0; k <= idx; k++) begin
      if (d[k] != 0) allZero = 1'b0;
    end
    if (idx < 3 && allZero) return 16'h0000;
    return 16'(16'h120 + d[idx]);
  endfunction

  task automatic applyStimulus(input logic r, input logic e, input logic [15:0] n);
    reset   = r;
    bus.en  = e;
    bus.num = n;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] expA, input logic [15:0] expD);
    testCount++;
    assert (bus.addr === expA) else begin
      failCount++;
      $error("[TB] FAIL %s addr: got %h expected %h (cyc %0d)", tag, bus.addr, expA, cyc);
    end
    testCount++;
    assert (bus.data === expD) else begin
      failCount++;
      $error("[TB] FAIL %s data: got %h expected %h (cyc %0d)", tag, bus.data, expD, cyc);
    end
  endtask

  // One clock: inputs are stable across the edge, outputs are checked 1 ns after it.
  task automatic tick();
    logic        r;
    logic        e;
    logic [15:0] n;
    int          p;
    r = reset;
    e = bus.en;
    n = bus.num;
    @(posedge clk);
    #1;
    if (r) begin
      cyc = 0;
      expAddrQ.delete();
      expDataQ.delete();
      lastAddr = 16'd36;
      lastData = 16'h0000;
      checkOutput("reset", lastAddr, lastData);
    end else if (e) begin
      cyc++;
      if ((cyc - 1) % 19 == 0) begin
        for (int i = 0; i < 4; i++) begin
          expAddrQ.push_back(16'(36 + i));
          expDataQ.push_back(expWord(int'(n), i));
        end
      end
      p = (cyc - 16) % 19;
      if (cyc >= 16 && p < 4) begin
        testCount++;
        assert (expAddrQ.size() > 0) else begin
          failCount++;
          $error("[TB] FAIL scoreboard: got empty queue expected word at cyc %0d", cyc);
        end
        if (expAddrQ.size() > 0) begin
          lastAddr = expAddrQ.pop_front();
          lastData = expDataQ.pop_front();
        end
        checkOutput("emit", lastAddr, lastData);
      end else begin
        checkOutput("hold", lastAddr, lastData);
      end
    end else begin
      checkOutput("frozen", lastAddr, lastData);
    end
  endtask

  task automatic runUntilPhase(input int ph);
    int  steps;
    bit  hit;
    steps = 0;
    hit   = 1'b0;
    while (!hit && steps < 40) begin
      tick();
      steps++;
      if (cyc > 0 && (cyc - 1) % 19 == ph) hit = 1'b1;
    end
    testCount++;
    assert (hit) else begin
      failCount++;
      $error("[TB] FAIL phase wait: got no phase %0d expected within 40 cycles", ph);
    end
  endtask

  task automatic runSweep(input logic [15:0] n);
    bus.num = n;
    runUntilPhase(0);
    runUntilPhase(18);
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    cyc       = 0;
    lastAddr  = 16'd36;
    lastData  = 16'h0000;

    applyStimulus(1'b1, 1'b1, 16'd0);
    repeat (3) tick();

    applyStimulus(1'b0, 1'b1, 16'd0);
    repeat (40) tick();

    bus.num = 16'd1234;
    runUntilPhase(0);
    runUntilPhase(5);
    bus.num = 16'd5678;
    runUntilPhase(0);
    runUntilPhase(18);

    runSweep(16'd9);
    runSweep(16'd50000);
    runSweep(16'd9999);
    runSweep(16'd1080);

    bus.num = 16'd4321;
    runUntilPhase(0);
    runUntilPhase(16);
    bus.en = 1'b0;
    repeat (10) tick();
    bus.en = 1'b1;
    runUntilPhase(18);

    bus.num = 16'd705;
    runUntilPhase(0);
    runUntilPhase(6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
